// File: rtl/aw_write_scheduler.sv
// ---------------------------------------------------------------------------
// aw_write_scheduler
//   Write-address scheduler for two AXI requesters (S00, S01) and two targets
//   (M00, M01). In IDLE it picks one eligible requester and registers its
//   address and decoded target. In ADDR it presents that address to the
//   target until the target accepts it, then pulses AW_Access_Grant and
//   returns to IDLE.
//
//   A requester is eligible when it is valid, the write-data queue is not
//   full, and its target has fewer than Max_Outstanding granted bursts whose
//   write data has not yet finished.
//
//   Optional feature macro: AW_SCHED_FIXED_PRIO_EN
//     defined   : S00 always wins when both are eligible (no RR pointer)
//     undefined : round-robin between S00 and S01
//
// Ports
//   ACLK, ARESET                : clock, asynchronous active-high reset
//   S0x_AXI_aw{valid,addr,ready}: requester AW channels
//   M0x_AXI_aw{valid,addr,ready}: target AW channels
//   Queue_Is_Full               : write-data queue back-pressure
//   Write_Data_Finsh(2)         : burst-done pulse for M00 (M01)
//   AW_Selected_Slave           : index of granted requester
//   AW_Access_Grant             : one-cycle pulse on AW handshake
//   Q_Enable_W_Data_In          : one-hot target queue select (bit0 = M00)
// ---------------------------------------------------------------------------
module aw_write_scheduler #(
    parameter int                       Slaves_Num      = 2,
    parameter int                       Slaves_ID_Size  = $clog2(Slaves_Num),
    parameter int                       Address_width   = 32,
    parameter logic [Address_width-1:0] M01_Base_Addr   = 32'h8000_0000,
    parameter int                       Max_Outstanding = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic                      S00_AXI_awvalid,
    input  logic [Address_width-1:0]  S00_AXI_awaddr,
    output logic                      S00_AXI_awready,
    input  logic                      S01_AXI_awvalid,
    input  logic [Address_width-1:0]  S01_AXI_awaddr,
    output logic                      S01_AXI_awready,

    output logic                      M00_AXI_awvalid,
    output logic [Address_width-1:0]  M00_AXI_awaddr,
    input  logic                      M00_AXI_awready,
    output logic                      M01_AXI_awvalid,
    output logic [Address_width-1:0]  M01_AXI_awaddr,
    input  logic                      M01_AXI_awready,

    input  logic                      Queue_Is_Full,
    input  logic                      Write_Data_Finsh,
    input  logic                      Write_Data_Finsh2,

    output logic [Slaves_ID_Size-1:0] AW_Selected_Slave,
    output logic                      AW_Access_Grant,
    output logic [1:0]                Q_Enable_W_Data_In
);

    localparam logic [3:0] MAX_CNT = 4'(Max_Outstanding);

    typedef enum logic {IDLE, ADDR} state_t;

    state_t state, state_nxt;

    // requester-side views, index 0 = S00, 1 = S01
    logic [1:0]                    s_vld;
    logic [1:0][Address_width-1:0] s_addr;
    logic [1:0]                    s_tgt;     // 1 = routes to M01
    logic [1:0]                    elig;
    logic                          win;

    // target-side views, index 0 = M00, 1 = M01
    logic [1:0][3:0]               cnt;
    logic [1:0]                    cnt_ok;
    logic [1:0]                    fin;

    logic [Slaves_ID_Size-1:0]     sel_q;
    logic                          tgt_q;
    logic [Address_width-1:0]      addr_q;
    logic                          m_rdy;
    logic                          hs;

    assign s_vld  = {S01_AXI_awvalid, S00_AXI_awvalid};
    assign s_addr = {S01_AXI_awaddr,  S00_AXI_awaddr};
    assign fin    = {Write_Data_Finsh2, Write_Data_Finsh};

    for (genvar i = 0; i < 2; i++) begin : g_req
        assign s_tgt[i] = (s_addr[i] >= M01_Base_Addr);
        assign elig[i]  = s_vld[i] && cnt_ok[s_tgt[i]] && !Queue_Is_Full;
    end

`ifdef AW_SCHED_FIXED_PRIO_EN
    assign win = !elig[0];
`else
    logic rr_ptr;   // requester favoured when both are eligible

    // only S01 eligible -> 1; only S00 -> 0; both -> pointer side
    assign win = (&elig) ? rr_ptr : elig[1];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            rr_ptr <= 1'b0;
        else if (hs)
            rr_ptr <= ~sel_q[0];
    end
`endif

    // ready of the target currently being addressed
    assign m_rdy = tgt_q ? M01_AXI_awready : M00_AXI_awready;
    assign hs    = (state == ADDR) && m_rdy;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Winner capture. Held across ADDR so requester changes cannot disturb
    // an address already being presented.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sel_q  <= '0;
            tgt_q  <= 1'b0;
            addr_q <= '0;
        end else if (state == IDLE && |elig) begin
            sel_q  <= Slaves_ID_Size'(win);
            tgt_q  <= s_tgt[win];
            addr_q <= s_addr[win];
        end
    end

    always_comb begin
        state_nxt          = state;
        M00_AXI_awvalid    = 1'b0;
        M00_AXI_awaddr     = '0;
        M01_AXI_awvalid    = 1'b0;
        M01_AXI_awaddr     = '0;
        S00_AXI_awready    = 1'b0;
        S01_AXI_awready    = 1'b0;
        AW_Access_Grant    = 1'b0;
        Q_Enable_W_Data_In = 2'b00;
        case (state)
            IDLE: begin
                if (|elig)
                    state_nxt = ADDR;
            end
            ADDR: begin
                if (tgt_q) begin
                    M01_AXI_awvalid = 1'b1;
                    M01_AXI_awaddr  = addr_q;
                end else begin
                    M00_AXI_awvalid = 1'b1;
                    M00_AXI_awaddr  = addr_q;
                end
                if (sel_q[0])
                    S01_AXI_awready = m_rdy;
                else
                    S00_AXI_awready = m_rdy;
                AW_Access_Grant    = m_rdy;
                Q_Enable_W_Data_In = tgt_q ? 2'b10 : 2'b01;
                if (m_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign AW_Selected_Slave = sel_q;

    // Outstanding-burst counters. A finish pulse at zero is spurious and
    // ignored; a grant and a real finish in the same cycle cancel out.
    for (genvar t = 0; t < 2; t++) begin : g_cnt
        logic inc, dec;
        assign inc       = hs && (tgt_q == 1'(t));
        assign dec       = fin[t] && (cnt[t] != 4'd0);
        assign cnt_ok[t] = (cnt[t] < MAX_CNT);

        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET)
                cnt[t] <= 4'd0;
            else if (inc && !dec && cnt[t] != MAX_CNT)
                cnt[t] <= cnt[t] + 4'd1;
            else if (dec && !inc)
                cnt[t] <= cnt[t] - 4'd1;
        end
    end

endmodule

// File: tb/tb_aw_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aw_write_scheduler
//   Directed, table-driven bench for aw_write_scheduler (default build,
//   round-robin arbitration, Max_Outstanding = 4). Each vector drives inputs
//   on the falling edge, checks outputs 1 ns later, and the following rising
//   edge advances the design.
// ---------------------------------------------------------------------------
module tb_aw_write_scheduler;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    localparam logic [31:0] A1   = 32'h0000_1000;
    localparam logic [31:0] A2   = 32'h0000_0100;
    localparam logic [31:0] B    = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] Z    = 32'h0000_0000;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        S00_AXI_awvalid = 1'b0, S01_AXI_awvalid = 1'b0;
    logic [31:0] S00_AXI_awaddr = '0, S01_AXI_awaddr = '0;
    logic        S00_AXI_awready, S01_AXI_awready;
    logic        M00_AXI_awvalid, M01_AXI_awvalid;
    logic [31:0] M00_AXI_awaddr, M01_AXI_awaddr;
    logic        M00_AXI_awready = 1'b0, M01_AXI_awready = 1'b0;
    logic        Queue_Is_Full = 1'b0;
    logic        Write_Data_Finsh = 1'b0, Write_Data_Finsh2 = 1'b0;
    logic [0:0]  AW_Selected_Slave;
    logic        AW_Access_Grant;
    logic [1:0]  Q_Enable_W_Data_In;

    int checks = 0;
    int fails  = 0;

    always #5 ACLK = ~ACLK;

    aw_write_scheduler dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .S00_AXI_awvalid    (S00_AXI_awvalid),
        .S00_AXI_awaddr     (S00_AXI_awaddr),
        .S00_AXI_awready    (S00_AXI_awready),
        .S01_AXI_awvalid    (S01_AXI_awvalid),
        .S01_AXI_awaddr     (S01_AXI_awaddr),
        .S01_AXI_awready    (S01_AXI_awready),
        .M00_AXI_awvalid    (M00_AXI_awvalid),
        .M00_AXI_awaddr     (M00_AXI_awaddr),
        .M00_AXI_awready    (M00_AXI_awready),
        .M01_AXI_awvalid    (M01_AXI_awvalid),
        .M01_AXI_awaddr     (M01_AXI_awaddr),
        .M01_AXI_awready    (M01_AXI_awready),
        .Queue_Is_Full      (Queue_Is_Full),
        .Write_Data_Finsh   (Write_Data_Finsh),
        .Write_Data_Finsh2  (Write_Data_Finsh2),
        .AW_Selected_Slave  (AW_Selected_Slave),
        .AW_Access_Grant    (AW_Access_Grant),
        .Q_Enable_W_Data_In (Q_Enable_W_Data_In)
    );

    typedef struct packed {
        logic        rst;
        logic        s0v;
        logic [31:0] s0a;
        logic        s1v;
        logic [31:0] s1a;
        logic        m0r;
        logic        m1r;
        logic        qf;
        logic        f0;
        logic        f1;
    } in_t;

    typedef struct packed {
        logic        m0v;
        logic [31:0] m0a;
        logic        m1v;
        logic [31:0] m1a;
        logic        s0r;
        logic        s1r;
        logic        gnt;
        logic        sel;
        logic [1:0]  qen;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    function automatic in_t mi(logic rst, logic s0v, logic [31:0] s0a,
                               logic s1v, logic [31:0] s1a, logic m0r,
                               logic m1r, logic qf, logic f0, logic f1);
        mi = '{rst, s0v, s0a, s1v, s1a, m0r, m1r, qf, f0, f1};
    endfunction

    // Expected outputs while waiting in IDLE: everything low, selection held.
    function automatic out_t idle_o(logic sel);
        idle_o     = '0;
        idle_o.sel = sel;
    endfunction

    // Expected outputs in ADDR for a hand-chosen winner/target/address.
    function automatic out_t addr_o(logic sel, logic tgt, logic [31:0] a, logic rdy);
        addr_o = '0;
        if (tgt) begin
            addr_o.m1v = H;
            addr_o.m1a = a;
            addr_o.qen = 2'b10;
        end else begin
            addr_o.m0v = H;
            addr_o.m0a = a;
            addr_o.qen = 2'b01;
        end
        if (sel) addr_o.s1r = rdy;
        else     addr_o.s0r = rdy;
        addr_o.gnt = rdy;
        addr_o.sel = sel;
    endfunction

    function automatic vec_t mv(in_t i, out_t o);
        mv = '{i, o};
    endfunction

    task automatic apply(input vec_t v, input string nm);
        out_t got;
        @(negedge ACLK);
        ARESET            = v.i.rst;
        S00_AXI_awvalid   = v.i.s0v;
        S00_AXI_awaddr    = v.i.s0a;
        S01_AXI_awvalid   = v.i.s1v;
        S01_AXI_awaddr    = v.i.s1a;
        M00_AXI_awready   = v.i.m0r;
        M01_AXI_awready   = v.i.m1r;
        Queue_Is_Full     = v.i.qf;
        Write_Data_Finsh  = v.i.f0;
        Write_Data_Finsh2 = v.i.f1;
        #1;
        got.m0v = M00_AXI_awvalid;
        got.m0a = M00_AXI_awaddr;
        got.m1v = M01_AXI_awvalid;
        got.m1a = M01_AXI_awaddr;
        got.s0r = S00_AXI_awready;
        got.s1r = S01_AXI_awready;
        got.gnt = AW_Access_Grant;
        got.sel = AW_Selected_Slave[0];
        got.qen = Q_Enable_W_Data_In;
        checks++;
        if (got !== v.o) begin
            fails++;
            $display("FAIL %s: got m0v=%b m0a=%h m1v=%b m1a=%h s0r=%b s1r=%b gnt=%b sel=%b qen=%b | expected m0v=%b m0a=%h m1v=%b m1a=%h s0r=%b s1r=%b gnt=%b sel=%b qen=%b",
                     nm, got.m0v, got.m0a, got.m1v, got.m1a, got.s0r, got.s1r,
                     got.gnt, got.sel, got.qen, v.o.m0v, v.o.m0a, v.o.m1v,
                     v.o.m1a, v.o.s0r, v.o.s1r, v.o.gnt, v.o.sel, v.o.qen);
        end
    endtask

    task automatic do_reset(input string nm);
        apply(mv(mi(H, L, Z, L, Z, L, L, L, L, L), idle_o(L)), nm);
    endtask

    // S00 -> M00 request: one IDLE cycle then an accepted ADDR cycle.
    // f0 optionally pulses M00's finish in the handshake cycle.
    task automatic grant_s0(input logic [31:0] a, input logic f0, input string nm);
        apply(mv(mi(L, H, a, L, Z, L, L, L, L, L), idle_o(L)), {nm, "_idle"});
        apply(mv(mi(L, H, a, L, Z, H, L, L, f0, L), addr_o(L, L, a, H)), {nm, "_grant"});
    endtask

    // S00 valid but its target is full: must stay in IDLE.
    task automatic held_s0(input logic [31:0] a, input string nm);
        apply(mv(mi(L, H, a, L, Z, H, L, L, L, L), idle_o(L)), nm);
    endtask

    vec_t tbl[$];

    initial begin
        // reset, first transaction, round-robin, address boundaries
        tbl.push_back(mv(mi(H, H, A1,   L, Z, L, L, L, L, L), idle_o(L)));
        tbl.push_back(mv(mi(L, H, A1,   L, Z, L, L, L, L, L), idle_o(L)));
        tbl.push_back(mv(mi(L, H, A1,   L, Z, H, L, L, L, L), addr_o(L, L, A1, H)));
        tbl.push_back(mv(mi(H, L, Z,    L, Z, L, L, L, L, L), idle_o(L)));
        tbl.push_back(mv(mi(L, H, A2,   H, B, H, H, L, L, L), idle_o(L)));
        tbl.push_back(mv(mi(L, H, A2,   H, B, H, H, L, L, L), addr_o(L, L, A2, H)));
        tbl.push_back(mv(mi(L, H, A2,   H, B, H, H, L, L, L), idle_o(L)));
        tbl.push_back(mv(mi(L, H, A2,   H, B, H, H, L, L, L), addr_o(H, H, B, H)));
        tbl.push_back(mv(mi(L, H, A2,   H, B, H, H, L, L, L), idle_o(H)));
        tbl.push_back(mv(mi(L, H, A2,   H, B, H, H, L, L, L), addr_o(L, L, A2, H)));
        tbl.push_back(mv(mi(L, H, ONES, L, Z, H, H, L, L, L), idle_o(L)));
        tbl.push_back(mv(mi(L, H, ONES, L, Z, H, H, L, L, L), addr_o(L, H, ONES, H)));
        tbl.push_back(mv(mi(L, L, Z,    H, Z, H, H, L, L, L), idle_o(L)));
        tbl.push_back(mv(mi(L, L, Z,    H, Z, H, H, L, L, L), addr_o(H, L, Z, H)));
        tbl.push_back(mv(mi(L, L, Z,    L, Z, L, L, L, L, L), idle_o(H)));

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k], $sformatf("tbl%0d", k));

        // outstanding limit: four grants fill M00, fifth waits for a finish
        do_reset("lim_rst");
        for (int k = 0; k < 4; k++)
            grant_s0(A1, L, $sformatf("lim_g%0d", k));
        held_s0(A1, "lim_held0");
        held_s0(A1, "lim_held1");
        apply(mv(mi(L, H, A1, L, Z, H, L, L, H, L), idle_o(L)), "lim_fin");
        apply(mv(mi(L, H, A1, L, Z, H, L, L, L, L), idle_o(L)), "lim_rearb");
        apply(mv(mi(L, H, A1, L, Z, H, L, L, L, L), addr_o(L, L, A1, H)), "lim_grant");
        apply(mv(mi(L, L, Z,  L, Z, L, L, L, L, L), idle_o(L)), "lim_done");

        // grant and finish together at count 2 leave it at 2: two more fit
        do_reset("sim_rst");
        grant_s0(A1, L, "sim_g0");
        grant_s0(A1, L, "sim_g1");
        grant_s0(A1, H, "sim_gf");
        grant_s0(A1, L, "sim_g3");
        grant_s0(A1, L, "sim_g4");
        held_s0(A1, "sim_held");

        // spurious finish at zero must not underflow: four grants still fit
        do_reset("spu_rst");
        apply(mv(mi(L, L, Z, L, Z, L, L, L, H, H), idle_o(L)), "spu_fin");
        for (int k = 0; k < 4; k++)
            grant_s0(A1, L, $sformatf("spu_g%0d", k));
        held_s0(A1, "spu_held");

        // queue full blocks arbitration but not an address already issued
        do_reset("qf_rst");
        apply(mv(mi(L, H, A1, L, Z, H, L, H, L, L), idle_o(L)), "qf_blk0");
        apply(mv(mi(L, H, A1, L, Z, H, L, H, L, L), idle_o(L)), "qf_blk1");
        apply(mv(mi(L, H, A1, L, Z, L, L, L, L, L), idle_o(L)), "qf_arb");
        for (int k = 0; k < 3; k++)
            apply(mv(mi(L, L, Z, L, Z, L, L, H, L, L), addr_o(L, L, A1, L)),
                  $sformatf("qf_wait%0d", k));
        apply(mv(mi(L, L, Z, L, Z, H, L, H, L, L), addr_o(L, L, A1, H)), "qf_grant");
        apply(mv(mi(L, L, Z, L, Z, L, L, L, L, L), idle_o(L)), "qf_done");

        // reset in ADDR abandons the request
        do_reset("ra_rst0");
        apply(mv(mi(L, L, Z, H, B, L, L, L, L, L), idle_o(L)), "ra_arb");
        apply(mv(mi(L, L, Z, H, B, L, L, L, L, L), addr_o(H, H, B, L)), "ra_addr");
        apply(mv(mi(H, L, Z, H, B, L, H, L, L, L), idle_o(L)), "ra_abort");
        apply(mv(mi(L, L, Z, L, Z, L, H, L, L, L), idle_o(L)), "ra_idle");
        apply(mv(mi(L, L, Z, H, B, L, H, L, L, L), idle_o(L)), "ra_arb2");
        apply(mv(mi(L, L, Z, H, B, L, H, L, L, L), addr_o(H, H, B, H)), "ra_grant");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/aw_write_scheduler.md
AW_WRITE_SCHEDULER -- requirements
Module: aw_write_scheduler

Interface
REQ-001 SHALL have parameter Slaves_Num, default 2, number of upstream requesters (S00, S01).
REQ-002 SHALL have parameter Slaves_ID_Size, default $clog2(Slaves_Num), requester index width.
REQ-003 SHALL have parameter Address_width, default 32, AW address width.
REQ-004 SHALL have parameter M01_Base_Addr, default 32'h8000_0000; awaddr >= base routes to M01, else M00.
REQ-005 SHALL have parameter Max_Outstanding, default 4, range 1..15; per-target limit on granted bursts whose write data is unfinished.
REQ-006 SHALL have ports: ACLK  in  1  clock; ARESET  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: S00_AXI_awvalid  in  1; S00_AXI_awaddr  in  Address_width; S00_AXI_awready  out  1; S01 equivalents identical.
REQ-008 SHALL have ports: M00_AXI_awvalid  out  1; M00_AXI_awaddr  out  Address_width; M00_AXI_awready  in  1; M01 equivalents identical.
REQ-009 SHALL have ports: Queue_Is_Full  in  1  write-data queue back-pressure; Write_Data_Finsh  in  1  M00 burst done pulse; Write_Data_Finsh2  in  1  M01 burst done pulse.
REQ-010 SHALL have ports: AW_Selected_Slave  out  Slaves_ID_Size  granted requester; AW_Access_Grant  out  1  grant pulse; Q_Enable_W_Data_In  out  2  one-hot target queue select.

Function
REQ-011 SHALL implement FSM states IDLE and ADDR.
REQ-012 In IDLE, SHALL mark requester eligible when awvalid=1, its decoded target's counter < Max_Outstanding, and Queue_Is_Full=0.
REQ-013 In IDLE with >=1 eligible, SHALL register winner (per REQ-024), its target and address, and enter ADDR next cycle; none eligible -> stay IDLE.
REQ-014 In ADDR, SHALL drive selected target's awvalid=1 with registered awaddr; non-selected target awvalid=0, awaddr=0.
REQ-015 In ADDR, SHALL route selected target's awready combinationally to the winner's S_awready; all other S_awready=0; S_awready=0 in IDLE.
REQ-016 In ADDR, awvalid SHALL stay high until awready=1 regardless of Queue_Is_Full or requester changes.
REQ-017 On ADDR handshake cycle, SHALL assert AW_Access_Grant=1 for exactly that cycle and return to IDLE next cycle.
REQ-018 AW_Selected_Slave SHALL equal registered winner while in ADDR and hold last value in IDLE.
REQ-019 Q_Enable_W_Data_In SHALL be one-hot of registered target (bit0=M00, bit1=M01) in ADDR, 2'b00 in IDLE.
REQ-020 Latency: awvalid sampled in IDLE cycle N -> M awvalid at N+1; grant throughput max one per 2 cycles.
REQ-021 Per-target counter SHALL increment on handshake to that target and decrement on its Finsh pulse; both same cycle -> unchanged.
REQ-022 Counter SHALL saturate: no increment beyond Max_Outstanding, no decrement below 0 (spurious Finsh ignored).
REQ-023 Address equal to M01_Base_Addr SHALL route to M01; all-ones address to M01; zero to M00.
REQ-024 Default arbitration round-robin: pointer starts at S00; after grant to Sx pointer moves to the other requester; both eligible -> pointer side wins; one eligible -> it wins, pointer then updated.

Reset
REQ-025 ARESET=1 SHALL asynchronously force IDLE, counters=0, RR pointer=S00, AW_Selected_Slave=0, registered address=0.
REQ-026 During and after reset, all awvalid, awready, AW_Access_Grant, Q_Enable_W_Data_In SHALL be 0; reset mid-ADDR abandons the request with no grant.
REQ-027 Reset deassertion SHALL take effect on next ACLK rising edge; first arbitration in the first IDLE cycle after.

Configuration
REQ-028 Macro AW_SCHED_FIXED_PRIO_EN defined: S00 SHALL always win when both eligible; RR pointer removed.
REQ-029 Macro undefined: round-robin per REQ-024.

Verification
REQ-030 Reset then S00 awvalid, addr 32'h0000_1000 -> M00_AXI_awvalid=1 next cycle; with awready, AW_Access_Grant pulse, AW_Selected_Slave=0, Q_Enable=2'b01.
REQ-031 S00 and S01 continuously valid, addrs 0x100 / 0x8000_0000, awready=1 -> grants alternate S00,S01,S00 every 2 cycles (macro undefined); all S00 (macro defined).
REQ-032 Max_Outstanding=4, four M00 grants, no Finsh -> fifth request held in IDLE; one Write_Data_Finsh pulse -> grant issued.
REQ-033 Grant and Write_Data_Finsh same cycle with counter=2 -> counter stays 2; Finsh with counter=0 -> stays 0.
REQ-034 Queue_Is_Full=1 in IDLE -> no grant; Queue_Is_Full rising during ADDR with awready low 3 cycles -> awvalid held, grant on awready.
REQ-035 ARESET asserted in ADDR before awready -> awvalid drops immediately, no grant, counters 0.
